fetch_stage: RTL and testbench

Instruction-fetch (IF) stage of the pipelined CPU, directly upstream of the ID stage and the client of `branch_predictor`. It holds the fetch address and runs the instruction-memory read handshake. It asks the predictor for the next PC and loads the IF/ID pipeline register with the instruction, its PC and the prediction made for it. Stall and flush/redirect requests from ID/EX are handled here, including dropping a read that was in flight when a flush arrived.

---
 rtl/fetch_stage.sv | 149 ++++++++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, the instruction-memory read
// handshake, a one-entry skid buffer for stalls and the IF/ID pipeline register.
module fetch_stage #(
    parameter int unsigned              WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0]     RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset,

    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,

    output logic [WORD_SIZE-1:0] bp_pc,
    input  logic [WORD_SIZE-1:0] predicted_pc,
    input  logic                 tag_match,

    input  logic                 stall,
    input  logic                 flush,
    input  logic [WORD_SIZE-1:0] redirect_pc,

    output logic                 if_id_valid,
    output logic [WORD_SIZE-1:0] if_id_instr,
    output logic [WORD_SIZE-1:0] if_id_pc,
    output logic [WORD_SIZE-1:0] if_id_pred_pc,
    output logic                 if_id_tag_match,
    output logic [WORD_SIZE-1:0] num_fetched
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    state_e               state_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] redir_q;

    logic [WORD_SIZE-1:0] sk_instr_q;
    logic [WORD_SIZE-1:0] sk_pc_q;
    logic [WORD_SIZE-1:0] sk_pred_q;
    logic                 sk_tm_q;

    logic                 if_id_valid_q;
    logic [WORD_SIZE-1:0] if_id_instr_q;
    logic [WORD_SIZE-1:0] if_id_pc_q;
    logic [WORD_SIZE-1:0] if_id_pred_pc_q;
    logic                 if_id_tag_match_q;
    logic [WORD_SIZE-1:0] num_fetched_q;

    // Request is gated by reset so the read line is low for the whole reset cycle.
    assign i_readM   = !reset && (state_q != S_HOLD);
    assign i_address = addr_q;
    assign bp_pc     = addr_q;

    assign if_id_valid     = if_id_valid_q;
    assign if_id_instr     = if_id_instr_q;
    assign if_id_pc        = if_id_pc_q;
    assign if_id_pred_pc   = if_id_pred_pc_q;
    assign if_id_tag_match = if_id_tag_match_q;
    assign num_fetched     = num_fetched_q;

    // Fetch control FSM with the IF/ID and skid registers it loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_FETCH;
            addr_q            <= RESET_PC;
            redir_q           <= '0;
            sk_instr_q        <= '0;
            sk_pc_q           <= '0;
            sk_pred_q         <= '0;
            sk_tm_q           <= 1'b0;
            if_id_valid_q     <= 1'b0;
            if_id_instr_q     <= '0;
            if_id_pc_q        <= '0;
            if_id_pred_pc_q   <= '0;
            if_id_tag_match_q <= 1'b0;
            num_fetched_q     <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (flush) begin
                        if_id_valid_q <= 1'b0;
                        if (i_ready) begin
                            addr_q <= redirect_pc;
                        end else begin
                            redir_q <= redirect_pc;
                            state_q <= S_DISCARD;
                        end
                    end else if (i_ready) begin
                        addr_q <= predicted_pc;
                        if (!stall) begin
                            if_id_valid_q     <= 1'b1;
                            if_id_instr_q     <= i_data;
                            if_id_pc_q        <= addr_q;
                            if_id_pred_pc_q   <= predicted_pc;
                            if_id_tag_match_q <= tag_match;
                            num_fetched_q     <= num_fetched_q + WORD_SIZE'(1);
                        end else begin
                            // Read completes under stall: park it in the skid buffer.
                            sk_instr_q <= i_data;
                            sk_pc_q    <= addr_q;
                            sk_pred_q  <= predicted_pc;
                            sk_tm_q    <= tag_match;
                            state_q    <= S_HOLD;
                        end
                    end else if (!stall) begin
                        if_id_valid_q <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (flush) begin
                        addr_q        <= redirect_pc;
                        if_id_valid_q <= 1'b0;
                        state_q       <= S_FETCH;
                    end else if (!stall) begin
                        if_id_valid_q     <= 1'b1;
                        if_id_instr_q     <= sk_instr_q;
                        if_id_pc_q        <= sk_pc_q;
                        if_id_pred_pc_q   <= sk_pred_q;
                        if_id_tag_match_q <= sk_tm_q;
                        num_fetched_q     <= num_fetched_q + WORD_SIZE'(1);
                        state_q           <= S_FETCH;
                    end
                end

                S_DISCARD: begin
                    // The stale read must finish before the redirected fetch starts.
                    if_id_valid_q <= 1'b0;
                    if (flush) begin
                        redir_q <= redirect_pc;
                    end
                    if (i_ready) begin
                        addr_q  <= flush ? redirect_pc : redir_q;
                        state_q <= S_FETCH;
                    end
                end

                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: latency-programmable memory model and a
// pc+1 predictor with one programmable taken entry.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic [15:0] bp_pc;
    logic [15:0] predicted_pc;
    logic        tag_match;
    logic        stall;
    logic        flush;
    logic [15:0] redirect_pc;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pred_pc;
    logic        if_id_tag_match;
    logic [15:0] num_fetched;

    int unsigned lat;
    int unsigned cnt;
    logic        tk_en;
    logic [15:0] tk_pc;
    logic [15:0] tk_target;

    int unsigned n_checks;
    int unsigned n_pass;

    fetch_stage #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .i_readM         (i_readM),
        .i_address       (i_address),
        .i_data          (i_data),
        .i_ready         (i_ready),
        .bp_pc           (bp_pc),
        .predicted_pc    (predicted_pc),
        .tag_match       (tag_match),
        .stall           (stall),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pred_pc   (if_id_pred_pc),
        .if_id_tag_match (if_id_tag_match),
        .num_fetched     (num_fetched)
    );

    always #5 clk = ~clk;

    // Memory: ready pulses in the lat-th cycle of a held request.
    assign i_ready = i_readM && (cnt == lat - 1);
    assign i_data  = i_address ^ 16'hA500;

    always_ff @(posedge clk) begin
        if (reset || !i_readM || i_ready) cnt <= 0;
        else                              cnt <= cnt + 1;
    end

    assign tag_match    = tk_en && (bp_pc == tk_pc);
    assign predicted_pc = tag_match ? tk_target : bp_pc + 16'd1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        lat = 1; tk_en = 1'b0; tk_pc = '0; tk_target = '0;
        stall = 1'b0; flush = 1'b0; redirect_pc = '0;
        reset = 1'b1;
        tick(); tick();
        check("rst_readM", 16'(i_readM), 16'd0);
        check("rst_valid", 16'(if_id_valid), 16'd0);
        check("rst_num", num_fetched, 16'd0);
        check("rst_addr", i_address, 16'h0000);
        reset = 1'b0;
        #1;
        check("post_rst_readM", 16'(i_readM), 16'd1);

        // Sequential stream, one per cycle
        for (int k = 0; k < 4; k++) begin
            tick();
            check("seq_valid", 16'(if_id_valid), 16'd1);
            check("seq_pc", if_id_pc, 16'(k));
            check("seq_num", num_fetched, 16'(k + 1));
        end
        check("seq_instr", if_id_instr, 16'h0003 ^ 16'hA500);
        check("seq_next_addr", i_address, 16'h0004);

        // Stall absorbed by the skid buffer
        tick();
        check("pc4", if_id_pc, 16'h0004);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_readM", 16'(i_readM), 16'd0);
            check("hold_pc", if_id_pc, 16'h0004);
            check("hold_num", num_fetched, 16'd5);
        end
        stall = 1'b0;
        tick();
        check("skid_pc", if_id_pc, 16'h0005);
        check("skid_instr", if_id_instr, 16'h0005 ^ 16'hA500);
        check("skid_num", num_fetched, 16'd6);
        check("resume_addr", i_address, 16'h0006);
        tick();
        check("pc6", if_id_pc, 16'h0006);

        // Predicted taken at pc 7
        tk_en = 1'b1; tk_pc = 16'h0007; tk_target = 16'h0020;
        tick();
        check("tk_pc", if_id_pc, 16'h0007);
        check("tk_pred", if_id_pred_pc, 16'h0020);
        check("tk_tm", 16'(if_id_tag_match), 16'd1);
        check("tk_next_addr", i_address, 16'h0020);
        tk_en = 1'b0;
        tick();
        check("tgt_pc", if_id_pc, 16'h0020);
        check("tgt_tm", 16'(if_id_tag_match), 16'd0);
        check("tgt_num", num_fetched, 16'd9);

        // Flush with read in flight (latency 3)
        lat = 3;
        flush = 1'b1; redirect_pc = 16'h0040;
        tick();
        flush = 1'b0;
        check("disc_valid", 16'(if_id_valid), 16'd0);
        check("disc_readM", 16'(i_readM), 16'd1);
        check("disc_addr", i_address, 16'h0021);
        tick();
        check("disc_valid2", 16'(if_id_valid), 16'd0);
        tick();
        check("redir_addr", i_address, 16'h0040);
        check("redir_valid", 16'(if_id_valid), 16'd0);
        check("redir_num", num_fetched, 16'd9);

        // Double flush while discarding: newest wins
        flush = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect_pc = 16'h0080;
        tick();
        flush = 1'b0;
        tick();
        check("dbl_addr", i_address, 16'h0080);
        check("dbl_valid", 16'(if_id_valid), 16'd0);
        lat = 1;
        tick();
        check("dbl_pc", if_id_pc, 16'h0080);
        check("dbl_num", num_fetched, 16'd10);

        // Flush and stall together in HOLD
        stall = 1'b1;
        tick();
        check("h_readM", 16'(i_readM), 16'd0);
        flush = 1'b1; redirect_pc = 16'h0100;
        tick();
        check("hf_valid", 16'(if_id_valid), 16'd0);
        check("hf_addr", i_address, 16'h0100);
        check("hf_readM", 16'(i_readM), 16'd1);
        check("hf_pc_kept", if_id_pc, 16'h0080);
        check("hf_num", num_fetched, 16'd10);
        flush = 1'b0; stall = 1'b0;
        tick();
        check("hf_load_pc", if_id_pc, 16'h0100);
        check("hf_load_num", num_fetched, 16'd11);

        // Flush coincident with a completing read
        flush = 1'b1; redirect_pc = 16'h0200;
        tick();
        flush = 1'b0;
        check("fr_valid", 16'(if_id_valid), 16'd0);
        check("fr_addr", i_address, 16'h0200);
        check("fr_num", num_fetched, 16'd11);
        tick();
        check("fr_pc", if_id_pc, 16'h0200);
        check("fr_num2", num_fetched, 16'd12);

        // Reset mid-fetch
        lat = 3;
        tick();
        reset = 1'b1;
        tick();
        check("mr_readM", 16'(i_readM), 16'd0);
        check("mr_valid", 16'(if_id_valid), 16'd0);
        check("mr_instr", if_id_instr, 16'h0000);
        check("mr_pc", if_id_pc, 16'h0000);
        check("mr_pred", if_id_pred_pc, 16'h0000);
        check("mr_tm", 16'(if_id_tag_match), 16'd0);
        check("mr_num", num_fetched, 16'd0);
        check("mr_addr", i_address, 16'h0000);
        reset = 1'b0;
        lat = 1;
        #1;
        check("mr_readM2", 16'(i_readM), 16'd1);
        tick();
        check("mr_load_pc", if_id_pc, 16'h0000);
        check("mr_load_num", num_fetched, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
